// File: rtl/pipe_pkg.sv
// pipe_pkg: shared occupancy encodings and default payload/counter widths for elastic stages
package pipe_pkg;
  localparam int PIPE_DW = 32;
  localparam int PIPE_CW = 16;
  localparam int PIPE_CNT_W = 16;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE = 2'd1;
  localparam logic [1:0] OCC_FULL = 2'd2;
endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// sat_counter: event counter that sticks at all-ones; clear wins over increment
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with 2-entry skid buffer, hold, flush and
// saturating stall/bubble counters
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DW = PIPE_DW,
  parameter int CW = PIPE_CW,
  parameter bit FLUSH_CLR_DATA = 1'b1,
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [CW-1:0]    in_ctrl,
  input  logic             hold,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CW-1:0]    out_ctrl,
  output logic [1:0]       occupancy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic          main_valid, skid_valid, nmain_valid, nskid_valid;
  logic [DW-1:0] main_data, skid_data, nmain_data, nskid_data;
  logic [CW-1:0] main_ctrl, skid_ctrl, nmain_ctrl, nskid_ctrl;
  logic          accept, pop;
  assign in_ready = !skid_valid && !hold;
  assign accept = in_valid && in_ready;
  assign pop = main_valid && out_ready && !hold;
  assign out_valid = main_valid;
  assign out_data = main_data;
  assign out_ctrl = main_valid ? main_ctrl : '0;
  assign occupancy = skid_valid ? OCC_FULL : main_valid ? OCC_ONE : OCC_EMPTY;
  // skid is only ever filled while main is valid, so main alone decides EMPTY vs ONE
  always_comb begin
    nmain_valid = main_valid;
    nmain_data = main_data;
    nmain_ctrl = main_ctrl;
    nskid_valid = skid_valid;
    nskid_data = skid_data;
    nskid_ctrl = skid_ctrl;
    if (flush) begin
      nmain_valid = 1'b0;
      nskid_valid = 1'b0;
      nmain_ctrl = '0;
      nskid_ctrl = '0;
      nmain_data = FLUSH_CLR_DATA ? '0 : main_data;
      nskid_data = FLUSH_CLR_DATA ? '0 : skid_data;
    end else if (skid_valid) begin
      if (pop) begin
        nmain_data = skid_data;
        nmain_ctrl = skid_ctrl;
        nskid_valid = 1'b0;
        nskid_ctrl = '0;
      end
    end else if (accept && (!main_valid || pop)) begin
      nmain_valid = 1'b1;
      nmain_data = in_data;
      nmain_ctrl = in_ctrl;
    end else if (accept) begin
      nskid_valid = 1'b1;
      nskid_data = in_data;
      nskid_ctrl = in_ctrl;
    end else if (pop) begin
      nmain_valid = 1'b0;
      nmain_ctrl = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_valid <= 1'b0;
      main_data <= '0;
      main_ctrl <= '0;
      skid_valid <= 1'b0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      main_valid <= nmain_valid;
      main_data <= nmain_data;
      main_ctrl <= nmain_ctrl;
      skid_valid <= nskid_valid;
      skid_data <= nskid_data;
      skid_ctrl <= nskid_ctrl;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .inc(hold || (main_valid && !out_ready)), .clr(cnt_clr), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_bubble (
    .clk(clk), .rst(rst), .inc(!main_valid), .clr(cnt_clr), .cnt(bubble_cnt)
  );
endmodule
